// File: rtl/esmile_mem_arbiter.sv
// esmile_mem_arbiter
//
// Shares the single EsmileCPU memory bus port between the instruction fetch unit (IFU) and the
// load/store unit (LSU). One transaction is in flight at a time: a request is granted in IDLE,
// presented on the memory bus in REQ until the memory accepts it, and the memory response is
// routed back to the owning requester as a one-cycle pulse after RESP.
//
// Build option:
//   ESMILE_ARB_RR_EN  defined   -> round-robin between IFU and LSU when both request in IDLE
//                     undefined -> fixed priority, LSU wins contention
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   ifu_req_*           IFU read request (valid/addr in, ready out)
//   ifu_rsp_*           IFU response pulse and fetch data
//   lsu_req_*           LSU request (valid/addr/we/wdata/wstrb in, ready out)
//   lsu_rsp_*           LSU response pulse and load data (0 for writes)
//   mem_req_*           registered request onto the memory bus, valid/ready handshake
//   mem_rsp_*           memory response (one per request)

module esmile_mem_arbiter #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            ifu_req_valid,
    input  logic [AW-1:0]   ifu_req_addr,
    output logic            ifu_req_ready,
    output logic            ifu_rsp_valid,
    output logic [DW-1:0]   ifu_rsp_rdata,

    input  logic            lsu_req_valid,
    input  logic [AW-1:0]   lsu_req_addr,
    input  logic            lsu_req_we,
    input  logic [DW-1:0]   lsu_req_wdata,
    input  logic [DW/8-1:0] lsu_req_wstrb,
    output logic            lsu_req_ready,
    output logic            lsu_rsp_valid,
    output logic [DW-1:0]   lsu_rsp_rdata,

    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_req_addr,
    output logic            mem_req_we,
    output logic [DW-1:0]   mem_req_wdata,
    output logic [DW/8-1:0] mem_req_wstrb,
    input  logic            mem_rsp_valid,
    input  logic [DW-1:0]   mem_rsp_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp
    } state_e;

    state_e state_q, state_d;

    logic owner_lsu_q;  // owner of the in-flight transaction: 1 = LSU, 0 = IFU
    logic grant_lsu;    // arbitration result, only meaningful while idle
    logic accept;       // a request is granted this cycle
    logic rsp_take;     // memory response consumed this cycle

`ifdef ESMILE_ARB_RR_EN
    logic last_lsu_q;   // last grant went to the LSU; reset value makes the first contention go to the IFU

    always_ff @(posedge clk) begin
        if (rst) begin
            last_lsu_q <= 1'b1;
        end else if (accept) begin
            last_lsu_q <= grant_lsu;
        end
    end
`endif

    always_comb begin
`ifdef ESMILE_ARB_RR_EN
        grant_lsu = (ifu_req_valid && lsu_req_valid) ? !last_lsu_q : lsu_req_valid;
`else
        grant_lsu = lsu_req_valid;
`endif
    end

    // Next-state and request-side handshake outputs
    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        rsp_take      = 1'b0;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ifu_req_valid || lsu_req_valid) begin
                    accept        = 1'b1;
                    ifu_req_ready = !grant_lsu;
                    lsu_req_ready = grant_lsu;
                    state_d       = StReq;
                end
            end
            StReq: begin
                if (mem_req_ready) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (mem_rsp_valid) begin
                    rsp_take = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign mem_req_valid = (state_q == StReq);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            owner_lsu_q   <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_we    <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
            ifu_rsp_valid <= 1'b0;
            ifu_rsp_rdata <= '0;
            lsu_rsp_valid <= 1'b0;
            lsu_rsp_rdata <= '0;
        end else begin
            state_q       <= state_d;
            ifu_rsp_valid <= 1'b0;
            lsu_rsp_valid <= 1'b0;

            // IFU transactions are always reads with no write payload
            if (accept) begin
                owner_lsu_q   <= grant_lsu;
                mem_req_addr  <= grant_lsu ? lsu_req_addr : ifu_req_addr;
                mem_req_we    <= grant_lsu && lsu_req_we;
                mem_req_wdata <= grant_lsu ? lsu_req_wdata : '0;
                mem_req_wstrb <= grant_lsu ? lsu_req_wstrb : '0;
            end

            // Only the owner's response registers change; the other side holds its data
            if (rsp_take) begin
                if (owner_lsu_q) begin
                    lsu_rsp_valid <= 1'b1;
                    lsu_rsp_rdata <= mem_req_we ? '0 : mem_rsp_rdata;
                end else begin
                    ifu_rsp_valid <= 1'b1;
                    ifu_rsp_rdata <= mem_req_we ? '0 : mem_rsp_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_esmile_mem_arbiter.sv
// Testbench for esmile_mem_arbiter: directed vector table, hand-written contention and
// reset-in-flight sequences, then randomized traffic against a transaction-level model.
module tb_esmile_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid;
    logic [AW-1:0] ifu_req_addr;
    logic          ifu_req_ready;
    logic          ifu_rsp_valid;
    logic [DW-1:0] ifu_rsp_rdata;
    logic          lsu_req_valid;
    logic [AW-1:0] lsu_req_addr;
    logic          lsu_req_we;
    logic [DW-1:0] lsu_req_wdata;
    logic [3:0]    lsu_req_wstrb;
    logic          lsu_req_ready;
    logic          lsu_rsp_valid;
    logic [DW-1:0] lsu_rsp_rdata;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_we;
    logic [DW-1:0] mem_req_wdata;
    logic [3:0]    mem_req_wstrb;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_rdata;

    always #5 clk = ~clk;

    esmile_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .ifu_req_valid(ifu_req_valid),
        .ifu_req_addr (ifu_req_addr),
        .ifu_req_ready(ifu_req_ready),
        .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rsp_rdata(ifu_rsp_rdata),
        .lsu_req_valid(lsu_req_valid),
        .lsu_req_addr (lsu_req_addr),
        .lsu_req_we   (lsu_req_we),
        .lsu_req_wdata(lsu_req_wdata),
        .lsu_req_wstrb(lsu_req_wstrb),
        .lsu_req_ready(lsu_req_ready),
        .lsu_rsp_valid(lsu_rsp_valid),
        .lsu_rsp_rdata(lsu_rsp_rdata),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_req_we   (mem_req_we),
        .mem_req_wdata(mem_req_wdata),
        .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifu_req_valid = 1'b0; ifu_req_addr  = '0;
        lsu_req_valid = 1'b0; lsu_req_addr  = '0; lsu_req_we = 1'b0;
        lsu_req_wdata = '0;   lsu_req_wstrb = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_all_reset(input string tag);
        chk({tag, "_ifu_ready"}, ifu_req_ready, 0);
        chk({tag, "_lsu_ready"}, lsu_req_ready, 0);
        chk({tag, "_mem_valid"}, mem_req_valid, 0);
        chk({tag, "_ifu_rsp_v"}, ifu_rsp_valid, 0);
        chk({tag, "_lsu_rsp_v"}, lsu_rsp_valid, 0);
        chk({tag, "_ifu_rdata"}, ifu_rsp_rdata, 0);
        chk({tag, "_lsu_rdata"}, lsu_rsp_rdata, 0);
        chk({tag, "_mem_fields"}, {mem_req_addr, mem_req_we, mem_req_wdata[30:0], mem_req_wstrb},
            0);
    endtask

    // Per-cycle directed vector: inputs applied, outputs expected in the same cycle
    typedef struct {
        logic        iv;  logic [31:0] ia;
        logic        lv;  logic [31:0] la; logic lwe; logic [31:0] lwd; logic [3:0] lws;
        logic        mrdy; logic mrv; logic [31:0] mrd;
        logic        e_ir; logic e_lr; logic e_mv;
        logic [31:0] e_ma; logic e_mwe; logic [31:0] e_mwd; logic [3:0] e_mws;
        logic        e_irv; logic [31:0] e_ird; logic e_lrv; logic [31:0] e_lrd;
    } vec_t;

    vec_t vec[20];

    // Transaction-level reference model
    logic        m_busy, m_sent, m_lsu, m_last_lsu;
    logic [31:0] m_addr, m_wdata;
    logic        m_we;
    logic [3:0]  m_wstrb;
    logic        m_irv, m_lrv;
    logic [31:0] m_ird, m_lrd;

    function automatic logic pick_lsu(input logic iv, input logic lv, input logic last_lsu);
        if (iv && lv) begin
`ifdef ESMILE_ARB_RR_EN
            return !last_lsu;
`else
            return 1'b1;
`endif
        end
        return lv;
    endfunction

    int   n_grants;
    int   got[4];
    int   exp_order[4];
    logic any, win, e_ir, e_lr, e_mv;

    initial begin
        //           iv ia         lv la        we wd           ws   rdy rv rd
        //           e_ir e_lr e_mv ma      mwe mwd           mws irv ird          lrv lrd
        vec[0]  = '{1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0,
                    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vec[1]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0,
                    0, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0};
        vec[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF,
                    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vec[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0};
        vec[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0};
        vec[5]  = '{0, 0, 1, 32'h2000, 1, 32'h12345678, 4'b0011, 0, 0, 0,
                    0, 1, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0};
        for (int i = 6; i <= 10; i++) begin
            vec[i] = '{0, 0, 0, 0, 0, 0, 0, (i == 10), 0, 0,
                       0, 0, 1, 32'h2000, 1, 32'h12345678, 4'b0011, 0, 32'hDEADBEEF, 0, 0};
        end
        vec[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D,
                    0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0};
        vec[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, 0};
        vec[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h11111111,
                    0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0};
        vec[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0};
        vec[15] = '{1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0,
                    1, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0};
        vec[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h22222222,
                    0, 0, 1, 32'h40, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0};
        vec[17] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0,
                    0, 0, 1, 32'h40, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0};
        vec[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55,
                    0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0};
        vec[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 0, 1, 32'h55, 0, 0};

        // Reset values
        reset_dut();
        @(negedge clk);
        chk_all_reset("reset");
        step();

        // Directed table
        for (int i = 0; i < 20; i++) begin
            ifu_req_valid = vec[i].iv;   ifu_req_addr  = vec[i].ia;
            lsu_req_valid = vec[i].lv;   lsu_req_addr  = vec[i].la;
            lsu_req_we    = vec[i].lwe;  lsu_req_wdata = vec[i].lwd; lsu_req_wstrb = vec[i].lws;
            mem_req_ready = vec[i].mrdy; mem_rsp_valid = vec[i].mrv; mem_rsp_rdata = vec[i].mrd;
            @(negedge clk);
            chk($sformatf("v%0d_ifu_ready", i), ifu_req_ready, vec[i].e_ir);
            chk($sformatf("v%0d_lsu_ready", i), lsu_req_ready, vec[i].e_lr);
            chk($sformatf("v%0d_mem_valid", i), mem_req_valid, vec[i].e_mv);
            if (vec[i].e_mv) begin
                chk($sformatf("v%0d_mem_addr", i), mem_req_addr, vec[i].e_ma);
                chk($sformatf("v%0d_mem_we", i), mem_req_we, vec[i].e_mwe);
                chk($sformatf("v%0d_mem_wdata", i), mem_req_wdata, vec[i].e_mwd);
                chk($sformatf("v%0d_mem_wstrb", i), mem_req_wstrb, vec[i].e_mws);
            end
            chk($sformatf("v%0d_ifu_rsp_v", i), ifu_rsp_valid, vec[i].e_irv);
            chk($sformatf("v%0d_ifu_rdata", i), ifu_rsp_rdata, vec[i].e_ird);
            chk($sformatf("v%0d_lsu_rsp_v", i), lsu_rsp_valid, vec[i].e_lrv);
            chk($sformatf("v%0d_lsu_rdata", i), lsu_rsp_rdata, vec[i].e_lrd);
            step();
        end

        // Contention: both request continuously, zero-wait memory
        reset_dut();
`ifdef ESMILE_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{1, 1, 1, 1};
`endif
        got = '{2, 2, 2, 2};
        n_grants = 0;
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h300;
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h400; lsu_req_we = 1'b0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hA5A50001;
        for (int c = 0; c < 40 && n_grants < 4; c++) begin
            @(negedge clk);
            chk("ready_onehot", ifu_req_ready & lsu_req_ready, 0);
            if (ifu_req_ready || lsu_req_ready) begin
                got[n_grants] = lsu_req_ready ? 1 : 0;
                n_grants++;
            end
            step();
        end
        chk("contention_grant_count", n_grants, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("contention_grant%0d", i), got[i], exp_order[i]);
        idle_inputs();
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hA5A50002;
        repeat (4) step();
        idle_inputs();

        // Reset while in RESP, then a late memory response
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h500;
        @(negedge clk);
        chk("rr_accept", ifu_req_ready, 1);
        step();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h77;
        @(negedge clk);
        chk_all_reset("after_rst");
        step();
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("late_rsp_ifu_v", ifu_rsp_valid, 0);
        chk("late_rsp_lsu_v", lsu_rsp_valid, 0);
        chk("late_rsp_mem_v", mem_req_valid, 0);
        step();
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h600;
        @(negedge clk);
        chk("post_rst_accept", ifu_req_ready, 1);
        step();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_mem_v", mem_req_valid, 1);
        chk("post_rst_mem_addr", mem_req_addr, 32'h600);
        step();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h99;
        step();
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ifu_rsp_v", ifu_rsp_valid, 1);
        chk("post_rst_ifu_rdata", ifu_rsp_rdata, 32'h99);
        chk("post_rst_lsu_rsp_v", lsu_rsp_valid, 0);
        step();

        // Randomized traffic against the model
        reset_dut();
        m_busy = 0; m_sent = 0; m_lsu = 0; m_last_lsu = 1;
        m_addr = 0; m_wdata = 0; m_we = 0; m_wstrb = 0;
        m_irv = 0; m_lrv = 0; m_ird = 0; m_lrd = 0;
        for (int c = 0; c < 3000; c++) begin
            ifu_req_valid = 1'($urandom_range(0, 1)); ifu_req_addr = $urandom;
            lsu_req_valid = 1'($urandom_range(0, 1)); lsu_req_addr = $urandom;
            lsu_req_we    = 1'($urandom_range(0, 1)); lsu_req_wdata = $urandom;
            lsu_req_wstrb = 4'($urandom);
            mem_req_ready = 1'($urandom_range(0, 1));
            mem_rsp_valid = ($urandom_range(0, 2) == 0);
            mem_rsp_rdata = $urandom;

            any  = ifu_req_valid || lsu_req_valid;
            win  = pick_lsu(ifu_req_valid, lsu_req_valid, m_last_lsu);
            e_ir = !m_busy && any && !win;
            e_lr = !m_busy && any && win;
            e_mv = m_busy && !m_sent;

            @(negedge clk);
            chk("rnd_ifu_ready", ifu_req_ready, e_ir);
            chk("rnd_lsu_ready", lsu_req_ready, e_lr);
            chk("rnd_mem_valid", mem_req_valid, e_mv);
            if (e_mv) begin
                chk("rnd_mem_fields", {mem_req_addr, mem_req_we, mem_req_wstrb},
                    {m_addr, m_we, m_wstrb});
                chk("rnd_mem_wdata", mem_req_wdata, m_wdata);
            end
            chk("rnd_ifu_rsp", {ifu_rsp_valid, ifu_rsp_rdata}, {m_irv, m_ird});
            chk("rnd_lsu_rsp", {lsu_rsp_valid, lsu_rsp_rdata}, {m_lrv, m_lrd});

            m_irv = 0;
            m_lrv = 0;
            if (m_busy && m_sent) begin
                if (mem_rsp_valid) begin
                    if (m_lsu) begin
                        m_lrv = 1; m_lrd = m_we ? 32'h0 : mem_rsp_rdata;
                    end else begin
                        m_irv = 1; m_ird = mem_rsp_rdata;
                    end
                    m_busy = 0;
                end
            end else if (m_busy) begin
                if (mem_req_ready) m_sent = 1;
            end else if (any) begin
                m_busy = 1; m_sent = 0; m_lsu = win; m_last_lsu = win;
                m_addr  = win ? lsu_req_addr : ifu_req_addr;
                m_we    = win && lsu_req_we;
                m_wdata = win ? lsu_req_wdata : 32'h0;
                m_wstrb = win ? lsu_req_wstrb : 4'h0;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/esmile_mem_arbiter.md
# esmile_mem_arbiter

Two-port memory arbiter that shares the single memory bus port of the EsmileCPU core between the instruction fetch unit (IFU) and the load/store unit (LSU). It accepts one request at a time, drives it onto the memory bus with a valid/ready handshake and waits for the memory response. It then returns the response to the requester that owns the transaction. It sits inside `esmilecpu_top`, between the IFU/LSU and the external memory interface.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width; `DW/8` strobe bits

Ports:
- `clk` in 1: core clock, all logic rising-edge
- `rst` in 1: synchronous, active-high reset
- `ifu_req_valid` in 1: IFU read request
- `ifu_req_addr` in AW: IFU fetch address
- `ifu_req_ready` out 1: IFU request accepted this cycle
- `ifu_rsp_valid` out 1: one-cycle pulse; `ifu_rsp_rdata` valid
- `ifu_rsp_rdata` out DW: fetch data
- `lsu_req_valid` in 1: LSU request
- `lsu_req_addr` in AW: LSU address
- `lsu_req_we` in 1: 1 = write, 0 = read
- `lsu_req_wdata` in DW: write data
- `lsu_req_wstrb` in DW/8: byte enables (writes only)
- `lsu_req_ready` out 1: LSU request accepted this cycle
- `lsu_rsp_valid` out 1: one-cycle pulse; read data or write acknowledge
- `lsu_rsp_rdata` out DW: load data (0 for writes)
- `mem_req_valid` out 1: request on memory bus
- `mem_req_ready` in 1: memory accepts request
- `mem_req_addr` out AW, `mem_req_we` out 1, `mem_req_wdata` out DW, `mem_req_wstrb` out DW/8: registered request fields
- `mem_rsp_valid` in 1: memory response (every request, read or write, gets exactly one)
- `mem_rsp_rdata` in DW: memory read data

## Operation
- FSM states: IDLE, REQ, RESP. At most one transaction outstanding.
- IDLE: if any `*_req_valid`, grant one requester. `<owner>_req_ready`=1 combinationally in that cycle only. Latch addr/we/wdata/wstrb and the owner bit. Next state: REQ. IFU requests latch we=0, wstrb=0, wdata=0.
- REQ: `mem_req_valid`=1 with latched fields, held stable until `mem_req_ready`=1. That cycle → RESP.
- RESP: wait for `mem_rsp_valid`. Capture `mem_rsp_rdata` into the owner's rdata register, or 0 if the latched we=1. Set the owner's rsp_valid for the next cycle. → IDLE.
- `*_req_ready` is never asserted outside IDLE. `mem_rsp_valid` in IDLE/REQ is ignored. `*_rsp_valid` lasts exactly one cycle. Only the owner's rsp_valid is asserted.
- A non-owner's rdata output holds its previous value.
- Reset values: state IDLE; all `*_ready`, `*_valid` outputs 0; `mem_req_*` fields 0; `ifu_rsp_rdata` = `lsu_rsp_rdata` = 0; owner 0; `last_grant` = LSU.
- Reset in REQ/RESP abandons the transaction; no response is delivered, and memory responses after reset are ignored.

## Timing
- Accept in cycle N → `mem_req_valid` high from N+1.
- `mem_req_ready` in cycle M → RESP from M+1; `mem_rsp_valid` is legal from M+1.
- `mem_rsp_valid` in cycle R → `<owner>_rsp_valid` and rdata in R+1, state IDLE in R+1. A new request can be accepted in R+1.
- Minimum turnaround with zero-wait memory: accept N, memory accept N+1, response N+2, owner response N+3, next accept N+3. Throughput is one transaction per 3 cycles.
- Requesters must hold `*_req_valid` and fields until ready. A request dropped before ready is not remembered.

## Configuration
- `ESMILE_ARB_RR_EN` defined: round-robin on contention, where both requests are valid in IDLE. The grant goes to the requester opposite `last_grant`, and `last_grant` updates on every grant. The first contention after reset goes to the IFU.
- Not defined: fixed priority, LSU always wins contention. `last_grant` is unused and may be removed.
- Single-requester behaviour is identical in both builds.

## Test plan
- Single IFU read at addr 0x100, memory ready same cycle, rsp 0xDEADBEEF one cycle later → `ifu_req_ready` pulse in N, `ifu_rsp_valid` with 0xDEADBEEF in N+3, `lsu_rsp_valid` stays 0.
- LSU write addr 0x2000, data 0x12345678, wstrb 0b0011, memory stalls `mem_req_ready` 4 cycles → fields stable all 5 REQ cycles, then `lsu_rsp_valid`=1 with rdata 0.
- Both request continuously for 4 transactions → with `ESMILE_ARB_RR_EN` the grant order is IFU, LSU, IFU, LSU; without it the order is LSU ×4 and IFU gets no grant.
- Spurious `mem_rsp_valid` in IDLE and REQ → no `*_rsp_valid`, state unchanged.
- `rst` asserted in RESP, then `mem_rsp_valid` arrives → no response pulse; all outputs at reset values; the next IFU request completes normally.
